// File: rtl/reg_file_ser_pkg.sv
// Shared types for the serial register-file master.
// Contents:
//   ADDR_WIDTH_DEF / DATA_WIDTH_DEF : default address / data widths
//   state_e                         : serialiser state encoding
//   op_e                            : request operation encoding
//   req_t                           : latched request {op, addr, wdata, id}
//   cnt_width()                     : bit-counter width for the serial phases
// req_t is sized by the package defaults, so the top-level widths are tied to
// these values; changing a width means changing it here.
package reg_file_ser_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 8;
  localparam int unsigned DATA_WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_ADDR  = 3'd2,
    ST_WDATA = 3'd3,
    ST_GAP   = 3'd4,
    ST_RDATA = 3'd5
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  typedef struct packed {
    op_e                       op;
    logic [ADDR_WIDTH_DEF-1:0] addr;
    logic [DATA_WIDTH_DEF-1:0] wdata;
    logic                      id;
  } req_t;

  // Counter must hold the index of the MSB of the longer serial phase.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m <= 32'd2) ? 32'd1 : $clog2(m);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
// Ports:
//   clk_i   : clock
//   rst_i   : synchronous active-high reset (pointer favours requester 0)
//   en_i    : arbitration window open this cycle
//   valid_i : request valid per requester
//   gnt_o   : one-hot grant (combinational); a grant is an accept
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [1:0] valid_i,
  output logic [1:0] gnt_o
);

  // last_q holds the index of the most recently granted requester.
  logic last_q, last_d;

  // Grant selection and pointer update.
  always_comb begin
    gnt_o  = 2'b00;
    last_d = last_q;
    if (en_i) begin
      if (valid_i == 2'b11) begin
        gnt_o = last_q ? 2'b01 : 2'b10;
      end else begin
        gnt_o = valid_i;
      end
    end else begin
      gnt_o = 2'b00;
    end
    if (gnt_o != 2'b00) begin
      last_d = gnt_o[1];
    end else begin
      last_d = last_q;
    end
  end

  // Pointer register; reset value makes requester 0 win the first tie.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/reg_file_ser_master.sv
// Two-port arbitrating master for the serial register-file interface.
// Accepts parallel read/write requests from two requesters, serialises each
// one (EN pulse, address MSB first, then write data or gap + read data) and
// returns a one-cycle response to the originating requester.
// Ports:
//   CLK, RST                 : clock, synchronous active-high reset
//   REQn_VALID/READY         : request handshake (READY combinational)
//   REQn_WRITE/ADDR/WDATA    : request payload
//   RSPn_VALID/RDATA         : completion pulse, read data (0 for writes)
//   WR_EN/RD_EN/DIN          : serial start pulses and serial address/data out
//   DOUT                     : serial read data in
//   BUSY                     : transaction in progress or pending
module reg_file_ser_master
  import reg_file_ser_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ0_VALID,
  output logic                  REQ0_READY,
  input  logic                  REQ0_WRITE,
  input  logic [ADDR_WIDTH-1:0] REQ0_ADDR,
  input  logic [DATA_WIDTH-1:0] REQ0_WDATA,
  output logic                  RSP0_VALID,
  output logic [DATA_WIDTH-1:0] RSP0_RDATA,
  input  logic                  REQ1_VALID,
  output logic                  REQ1_READY,
  input  logic                  REQ1_WRITE,
  input  logic [ADDR_WIDTH-1:0] REQ1_ADDR,
  input  logic [DATA_WIDTH-1:0] REQ1_WDATA,
  output logic                  RSP1_VALID,
  output logic [DATA_WIDTH-1:0] RSP1_RDATA,
  output logic                  WR_EN,
  output logic                  RD_EN,
  output logic                  DIN,
  input  logic                  DOUT,
  output logic                  BUSY
);

  localparam int unsigned    CW        = cnt_width(ADDR_WIDTH, DATA_WIDTH);
  localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  req_t                  cur_q, cur_d;
  req_t                  pend_q, pend_d;
  logic                  pend_vld_q, pend_vld_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  rsp0_valid_q, rsp0_valid_d;
  logic                  rsp1_valid_q, rsp1_valid_d;
  logic [DATA_WIDTH-1:0] rsp0_rdata_q, rsp0_rdata_d;
  logic [DATA_WIDTH-1:0] rsp1_rdata_q, rsp1_rdata_d;

  logic                  wr_en, rd_en, din;
  logic                  in_data, penult, arb_en, arb_accept, finish;
  logic [1:0]            gnt;
  logic [DATA_WIDTH-1:0] fin_rdata;
  req_t                  acc_req;

  // Requests are taken when idle, or into the pending slot during the
  // penultimate data bit so the next op can start with the final bit.
  assign in_data    = (state_q == ST_WDATA) || (state_q == ST_RDATA);
  assign penult     = in_data && (cnt_q == CW'(1)) && !pend_vld_q;
  assign arb_en     = !RST && ((state_q == ST_IDLE) || penult);
  assign arb_accept = gnt[0] || gnt[1];

  rr_arb2 u_arb (
    .clk_i   (CLK),
    .rst_i   (RST),
    .en_i    (arb_en),
    .valid_i ({REQ1_VALID, REQ0_VALID}),
    .gnt_o   (gnt)
  );

  assign REQ0_READY = gnt[0];
  assign REQ1_READY = gnt[1];

  // Payload of the granted requester.
  always_comb begin
    acc_req.id = gnt[1];
    if (gnt[1]) begin
      acc_req.op    = REQ1_WRITE ? OP_WRITE : OP_READ;
      acc_req.addr  = REQ1_ADDR;
      acc_req.wdata = REQ1_WDATA;
    end else begin
      acc_req.op    = REQ0_WRITE ? OP_WRITE : OP_READ;
      acc_req.addr  = REQ0_ADDR;
      acc_req.wdata = REQ0_WDATA;
    end
  end

  // Next-state, serial outputs and response generation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cur_d        = cur_q;
    pend_d       = pend_q;
    pend_vld_d   = pend_vld_q;
    shreg_d      = shreg_q;
    rsp0_valid_d = 1'b0;
    rsp1_valid_d = 1'b0;
    rsp0_rdata_d = rsp0_rdata_q;
    rsp1_rdata_d = rsp1_rdata_q;
    wr_en        = 1'b0;
    rd_en        = 1'b0;
    din          = 1'b0;
    finish       = 1'b0;
    fin_rdata    = '0;

    case (state_q)
      ST_IDLE: begin
        if (arb_accept) begin
          cur_d   = acc_req;
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        wr_en   = (cur_q.op == OP_WRITE);
        rd_en   = (cur_q.op == OP_READ);
        state_d = ST_ADDR;
        cnt_d   = ADDR_LAST;
      end
      ST_ADDR: begin
        din = cur_q.addr[cnt_q];
        if (cnt_q == CW'(0)) begin
          state_d = (cur_q.op == OP_WRITE) ? ST_WDATA : ST_GAP;
          cnt_d   = DATA_LAST;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_WDATA: begin
        din = cur_q.wdata[cnt_q];
        if (cnt_q == CW'(0)) begin
          finish = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_GAP: begin
        state_d = ST_RDATA;
        cnt_d   = DATA_LAST;
      end
      ST_RDATA: begin
        // DOUT carries the bit for this cycle; capture it at the closing edge.
        shreg_d = {shreg_q[DATA_WIDTH-2:0], DOUT};
        if (cnt_q == CW'(0)) begin
          finish    = 1'b1;
          fin_rdata = shreg_d;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (finish) begin
      if (cur_q.id) begin
        rsp1_valid_d = 1'b1;
        rsp1_rdata_d = fin_rdata;
      end else begin
        rsp0_valid_d = 1'b1;
        rsp0_rdata_d = fin_rdata;
      end
      // Pending op starts alongside the final bit and skips START.
      if (pend_vld_q) begin
        wr_en      = (pend_q.op == OP_WRITE);
        rd_en      = (pend_q.op == OP_READ);
        cur_d      = pend_q;
        pend_vld_d = 1'b0;
        state_d    = ST_ADDR;
        cnt_d      = ADDR_LAST;
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      finish = 1'b0;
    end

    if (arb_accept && (state_q != ST_IDLE)) begin
      pend_d     = acc_req;
      pend_vld_d = 1'b1;
    end else begin
      pend_d = pend_d;
    end
  end

  // State and datapath registers; reset abandons any transaction silently.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      cur_q        <= '0;
      pend_q       <= '0;
      pend_vld_q   <= 1'b0;
      shreg_q      <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_rdata_q <= '0;
      rsp1_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cur_q        <= cur_d;
      pend_q       <= pend_d;
      pend_vld_q   <= pend_vld_d;
      shreg_q      <= shreg_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_rdata_q <= rsp0_rdata_d;
      rsp1_rdata_q <= rsp1_rdata_d;
    end
  end

  assign WR_EN      = wr_en;
  assign RD_EN      = rd_en;
  assign DIN        = din;
  assign BUSY       = (state_q != ST_IDLE) || pend_vld_q;
  assign RSP0_VALID = rsp0_valid_q;
  assign RSP1_VALID = rsp1_valid_q;
  assign RSP0_RDATA = rsp0_rdata_q;
  assign RSP1_RDATA = rsp1_rdata_q;

endmodule
